// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and PC arithmetic for the instruction fetch sequencer.
package fetch_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam logic [3:0] HALT_OP = 4'hF;
  localparam int DEF_DEPTH = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_HOLD   = 2'd2;
  localparam state_t ST_HALTED = 2'd3;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc, input int depth);
    return (32'(pc) >= 32'(depth - 1)) ? '0 : pc + ADDR_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] pc_mod(input logic [ADDR_W-1:0] pc, input int depth);
    return ADDR_W'(32'(pc) % 32'(depth));
  endfunction
endpackage

// File: rtl/fetch_skid_reg.sv
// Single-entry hold register that parks a stalled instruction and its PC.
module fetch_skid_reg
  import fetch_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  // Clear wins over load so a redirect or halt never leaves a stale entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives a 1-cycle-latency instruction memory and presents instr/PC/valid to IF/ID.
// Handshake: an instruction is transferred when ValidOut=1 and Stall=0; Redirect kills ValidOut that cycle.
module fetch_sequencer #(
  parameter int                           DEPTH    = fetch_pkg::DEF_DEPTH,
  parameter logic [fetch_pkg::ADDR_W-1:0] RESET_PC = 16'h0,
  parameter logic [3:0]                   HALT_OP  = fetch_pkg::HALT_OP
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            Start,
  input  logic                            Stall,
  input  logic                            Redirect,
  input  logic [fetch_pkg::ADDR_W-1:0]    RedirectPc,
  input  logic [fetch_pkg::INSTR_W-1:0]   Instruction,
  output logic [fetch_pkg::ADDR_W-1:0]    ReadAddress,
  output logic [fetch_pkg::INSTR_W-1:0]   InstrOut,
  output logic [fetch_pkg::ADDR_W-1:0]    PcOut,
  output logic                            ValidOut,
  output logic                            Halted,
  output logic [15:0]                     FetchCount,
  output logic [1:0]                      o_dbg_state
);
  import fetch_pkg::*;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc_q;
  logic               r_req_q;
  logic [ADDR_W-1:0]  r_req_pc_q;
  logic [15:0]        r_fetch_count;

  logic               w_hold_v;
  logic [INSTR_W-1:0] w_hold_instr;
  logic [ADDR_W-1:0]  w_hold_pc;
  logic               w_hold_load;
  logic               w_hold_clear;
  logic               w_redirect;
  logic               w_valid;
  logic [INSTR_W-1:0] w_instr_out;
  logic [ADDR_W-1:0]  w_pc_out;
  logic               w_consume;
  logic               w_halt;

  // Redirect has no meaning before the first Start.
  assign w_redirect  = Redirect & (r_state != ST_IDLE);
  assign w_valid     = (w_hold_v | r_req_q) & ~w_redirect;
  assign w_instr_out = w_valid ? (w_hold_v ? w_hold_instr : Instruction) : '0;
  assign w_pc_out    = w_valid ? (w_hold_v ? w_hold_pc : r_req_pc_q) : '0;
  assign w_consume   = w_valid & ~Stall;
  assign w_halt      = w_consume & (w_instr_out[OPC_MSB:OPC_LSB] == HALT_OP);

  assign w_hold_load  = (r_state == ST_RUN) & Stall & w_valid;
  assign w_hold_clear = w_redirect | w_halt | ((r_state == ST_HOLD) & ~Stall);

  fetch_skid_reg u_skid (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_instr (w_instr_out),
    .i_pc    (w_pc_out),
    .o_valid (w_hold_v),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_pc_q        <= RESET_PC;
      r_req_q       <= 1'b0;
      r_req_pc_q    <= '0;
      r_fetch_count <= '0;
    end else begin
      if (w_consume) begin
        r_fetch_count <= r_fetch_count + 16'd1;
      end
      if (w_redirect) begin
        r_state <= ST_RUN;
        r_req_q <= 1'b0;
        r_pc_q  <= pc_mod(RedirectPc, DEPTH);
      end else if (w_halt) begin
        r_state <= ST_HALTED;
        r_req_q <= 1'b0;
        r_pc_q  <= pc_inc(w_pc_out, DEPTH);
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_req_q <= 1'b0;
            if (Start) begin
              r_state    <= ST_RUN;
              r_req_q    <= 1'b1;
              r_req_pc_q <= RESET_PC;
              r_pc_q     <= pc_inc(RESET_PC, DEPTH);
            end
          end
          ST_RUN: begin
            if (Stall) begin
              // The word returning next cycle is dropped; pc_q re-issues it later.
              r_req_q <= 1'b0;
              if (w_valid) begin
                r_state <= ST_HOLD;
              end
            end else begin
              r_req_q    <= 1'b1;
              r_req_pc_q <= r_pc_q;
              r_pc_q     <= pc_inc(r_pc_q, DEPTH);
            end
          end
          ST_HOLD: begin
            if (Stall) begin
              r_req_q <= 1'b0;
            end else begin
              r_state    <= ST_RUN;
              r_req_q    <= 1'b1;
              r_req_pc_q <= r_pc_q;
              r_pc_q     <= pc_inc(r_pc_q, DEPTH);
            end
          end
          ST_HALTED: begin
            r_req_q <= 1'b0;
            if (Start) begin
              r_state    <= ST_RUN;
              r_req_q    <= 1'b1;
              r_req_pc_q <= r_pc_q;
              r_pc_q     <= pc_inc(r_pc_q, DEPTH);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ReadAddress = r_pc_q;
  assign InstrOut    = w_instr_out;
  assign PcOut       = w_pc_out;
  assign ValidOut    = w_valid;
  assign Halted      = (r_state == ST_HALTED);
  assign FetchCount  = r_fetch_count;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer with a behavioural 1-cycle-latency instruction memory.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        Start;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectPc;
  logic [15:0] Instruction;
  logic [15:0] ReadAddress;
  logic [15:0] InstrOut;
  logic [15:0] PcOut;
  logic        ValidOut;
  logic        Halted;
  logic [15:0] FetchCount;
  logic [1:0]  dbg_state;

  logic [15:0] mem [16];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .Start       (Start),
    .Stall       (Stall),
    .Redirect    (Redirect),
    .RedirectPc  (RedirectPc),
    .Instruction (Instruction),
    .ReadAddress (ReadAddress),
    .InstrOut    (InstrOut),
    .PcOut       (PcOut),
    .ValidOut    (ValidOut),
    .Halted      (Halted),
    .FetchCount  (FetchCount),
    .o_dbg_state (dbg_state)
  );

  // clock / memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) Instruction <= mem[ReadAddress[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int pc, input logic [15:0] instr);
    exp_q.push_back({16'(pc), instr});
  endtask

  // scoreboard: every transfer (ValidOut & ~Stall) must match the next expected word
  always @(negedge clk) begin
    logic [31:0] want;
    if (rst && ValidOut && !Stall) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("sb_xfer", {PcOut, InstrOut}, want);
    end
  end

  initial begin
    rst = 1'b0; Start = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPc = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);

    // reset values
    #3;
    chk("rst_valid", 32'(ValidOut), 0);
    chk("rst_halted", 32'(Halted), 0);
    chk("rst_count", 32'(FetchCount), 0);
    chk("rst_raddr", 32'(ReadAddress), 0);
    chk("rst_instr", 32'(InstrOut), 0);
    chk("rst_pc", 32'(PcOut), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick(); tick();
    rst = 1'b1;

    // Redirect is ignored in IDLE
    Redirect = 1'b1; RedirectPc = 16'd7; #1;
    chk("idle_redir_valid", 32'(ValidOut), 0);
    tick();
    Redirect = 1'b0; #1;
    chk("idle_redir_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("idle_redir_raddr", 32'(ReadAddress), 0);

    // Start and first three transfers
    Start = 1'b1; #1;
    chk("start_raddr", 32'(ReadAddress), 0);
    tick();
    Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_exp(k, 16'h1000 + 16'(k)); #1;
      chk("run_valid", 32'(ValidOut), 1);
      chk("run_raddr", 32'(ReadAddress), 32'(k + 1));
      tick();
    end

    // stall three cycles on 1003
    for (int k = 0; k < 3; k++) begin
      Stall = 1'b1; #1;
      chk("stall_valid", 32'(ValidOut), 1);
      chk("stall_instr", 32'(InstrOut), 32'h1003);
      chk("stall_pc", 32'(PcOut), 3);
      chk("stall_raddr", 32'(ReadAddress), 4);
      tick();
    end
    Stall = 1'b0;
    push_exp(3, 16'h1003); #1;
    chk("release_count", 32'(FetchCount), 3);
    tick();
    push_exp(4, 16'h1004); #1;
    chk("after_release_instr", 32'(InstrOut), 32'h1004);
    chk("after_release_count", 32'(FetchCount), 4);
    tick();

    // run across the DEPTH wrap
    for (int k = 5; k < 18; k++) begin
      push_exp(k % 16, 16'h1000 + 16'(k % 16)); #1;
      chk("wrap_raddr", 32'(ReadAddress), 32'((k + 1) % 16));
      tick();
    end

    // Redirect to 9 while stalled
    Redirect = 1'b1; Stall = 1'b1; RedirectPc = 16'd9; #1;
    chk("redir_t_valid", 32'(ValidOut), 0);
    chk("redir_t_count", 32'(FetchCount), 18);
    tick();
    Redirect = 1'b0; Stall = 1'b0; #1;
    chk("redir_t1_valid", 32'(ValidOut), 0);
    chk("redir_t1_raddr", 32'(ReadAddress), 9);
    chk("redir_t1_state", 32'(dbg_state), 32'(ST_RUN));
    tick();
    push_exp(9, 16'h1009); #1;
    chk("redir_t2_valid", 32'(ValidOut), 1);
    chk("redir_t2_instr", 32'(InstrOut), 32'h1009);
    chk("redir_t2_pc", 32'(PcOut), 9);
    tick();
    push_exp(10, 16'h100A);
    tick();

    // out-of-range redirect target is reduced mod DEPTH
    Redirect = 1'b1; RedirectPc = 16'h0013; #1;
    chk("mod_t_valid", 32'(ValidOut), 0);
    chk("mod_t_count", 32'(FetchCount), 20);
    tick();
    Redirect = 1'b0; #1;
    chk("mod_t1_valid", 32'(ValidOut), 0);
    chk("mod_t1_raddr", 32'(ReadAddress), 3);
    tick();
    push_exp(3, 16'h1003); #1;
    chk("mod_t2_pc", 32'(PcOut), 3);
    tick();
    push_exp(4, 16'h1004);
    tick();

    // enter HOLD on 1005, then reset asynchronously mid-cycle
    Stall = 1'b1; #1;
    chk("hold_in_count", 32'(FetchCount), 22);
    tick(); #1;
    chk("hold_state", 32'(dbg_state), 32'(ST_HOLD));
    chk("hold_instr", 32'(InstrOut), 32'h1005);
    rst = 1'b0; #1;
    chk("arst_valid", 32'(ValidOut), 0);
    chk("arst_count", 32'(FetchCount), 0);
    chk("arst_raddr", 32'(ReadAddress), 0);
    chk("arst_instr", 32'(InstrOut), 0);
    chk("arst_pc", 32'(PcOut), 0);
    chk("arst_halted", 32'(Halted), 0);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    Stall = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("post_rst_valid", 32'(ValidOut), 0);
      tick();
    end

    // halt opcode at PC5
    mem[5] = 16'hF000;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      push_exp(k, (k == 5) ? 16'hF000 : 16'h1000 + 16'(k)); #1;
      chk("pre_halt_valid", 32'(ValidOut), 1);
      tick();
    end
    #1;
    chk("halt_flag", 32'(Halted), 1);
    chk("halt_valid", 32'(ValidOut), 0);
    chk("halt_count", 32'(FetchCount), 6);
    chk("halt_raddr", 32'(ReadAddress), 6);
    tick();
    tick(); #1;
    chk("halt_count_hold", 32'(FetchCount), 6);
    chk("halt_valid_hold", 32'(ValidOut), 0);
    Start = 1'b1; #1;
    chk("resume_start_valid", 32'(ValidOut), 0);
    tick();
    Start = 1'b0;
    push_exp(6, 16'h1006); #1;
    chk("resume_pc", 32'(PcOut), 6);
    chk("resume_halted", 32'(Halted), 0);
    tick();
    push_exp(7, 16'h1007);
    tick();
    Stall = 1'b1;
    tick(); tick();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
